// File: rtl/int_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// int_ctrl_pkg
// Shared definitions for the interrupt controller: CSR select codes, the
// sequencer state encoding, the GIE bit position inside MASK, and the default
// vector layout.
// -----------------------------------------------------------------------------
package int_ctrl_pkg;

    // CSR select values driven on csr_addr
    localparam logic [1:0] INT_MASK  = 2'd0;
    localparam logic [1:0] INT_PEND  = 2'd1;
    localparam logic [1:0] INT_EPC   = 2'd2;
    localparam logic [1:0] INT_CAUSE = 2'd3;

    // Global interrupt enable lives in MASK[15]; CAUSE[15] mirrors int_active
    localparam int GIE_BIT = 15;

    // Default vector table: irq 0 at VEC_BASE_DEF, one slot every VEC_STRIDE_DEF
    localparam logic [15:0] VEC_BASE_DEF   = 16'h0040;
    localparam int          VEC_STRIDE_DEF = 4;

    // Sequencer states
    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_DRAIN   = 3'd1,
        ST_CAPTURE = 3'd2,
        ST_SERVICE = 3'd3,
        ST_RETURN  = 3'd4
    } state_e;

endpackage

// File: rtl/int_ctrl_if.sv
// -----------------------------------------------------------------------------
// int_ctrl_if
// Bundle between the pipeline (master) and the interrupt controller (slave).
//   irq                 : request lines, rising-edge sensitive
//   csr_we/addr/wdata   : CSRW path; csr_rdata is the CSRR result
//   pc_id, id_valid     : return address and validity of the ID stage
//   mem_busy, jump_busy : in-flight operations that must drain first
//   iret                : return-from-interrupt pulse from decode
//   stall, flush, pc_redirect, pc_target : pipeline control back to the core
//   int_active, int_id  : service status
// -----------------------------------------------------------------------------
interface int_ctrl_if #(
    parameter int N_IRQ  = 4,
    parameter int DATA_W = 16
) ();

    logic [N_IRQ-1:0]  irq;
    logic              csr_we;
    logic [1:0]        csr_addr;
    logic [DATA_W-1:0] csr_wdata;
    logic [DATA_W-1:0] csr_rdata;
    logic [DATA_W-1:0] pc_id;
    logic              id_valid;
    logic              mem_busy;
    logic              jump_busy;
    logic              iret;
    logic              stall;
    logic              flush;
    logic              pc_redirect;
    logic [DATA_W-1:0] pc_target;
    logic              int_active;
    logic [2:0]        int_id;

    modport slave (
        input  irq, csr_we, csr_addr, csr_wdata, pc_id, id_valid,
               mem_busy, jump_busy, iret,
        output csr_rdata, stall, flush, pc_redirect, pc_target,
               int_active, int_id
    );

    modport master (
        output irq, csr_we, csr_addr, csr_wdata, pc_id, id_valid,
               mem_busy, jump_busy, iret,
        input  csr_rdata, stall, flush, pc_redirect, pc_target,
               int_active, int_id
    );

endinterface

// File: rtl/int_ctrl_prio_enc.sv
// -----------------------------------------------------------------------------
// int_prio_enc
// Combinational lowest-index priority encoder.
//   i_req   : N request bits
//   o_valid : at least one request bit set
//   o_idx   : index of the lowest set bit (0 when none)
// -----------------------------------------------------------------------------
module int_prio_enc #(
    parameter int N = 4
) (
    input  logic [N-1:0] i_req,
    output logic         o_valid,
    output logic [2:0]   o_idx
);

    // Scan from the top down so the lowest set bit is the last one to land
    always_comb begin
        o_valid = 1'b0;
        o_idx   = 3'd0;
        for (int i = N - 1; i >= 0; i--) begin
            o_idx   = i_req[i] ? 3'(i) : o_idx;
            o_valid = o_valid | i_req[i];
        end
    end

endmodule

// File: rtl/int_ctrl.sv
// -----------------------------------------------------------------------------
// int_ctrl
// Interrupt controller and pipeline sequencer for the 16-bit pipelined core.
// Latches irq edges into PEND, holds MASK/GIE, EPC and CAUSE, and when an
// enabled interrupt is pending it stalls fetch, waits for memory and jump
// operations to drain, captures the return PC, flushes ID and redirects to
// the vector. iret restores the PC from EPC.
//   clk   : core clock
//   rst_n : synchronous active-low reset
//   bus   : int_ctrl_if slave port (CSR path, pipeline status and control)
// -----------------------------------------------------------------------------
module int_ctrl
    import int_ctrl_pkg::*;
#(
    parameter int                N_IRQ      = 4,
    parameter int                DATA_W     = 16,
    parameter logic [DATA_W-1:0] VEC_BASE   = VEC_BASE_DEF,
    parameter int                VEC_STRIDE = VEC_STRIDE_DEF
) (
    input logic       clk,
    input logic       rst_n,
    int_ctrl_if.slave bus
);

    state_e            r_state;
    state_e            w_next_state;

    logic [N_IRQ-1:0]  r_mask;
    logic [N_IRQ-1:0]  r_pend;
    logic [N_IRQ-1:0]  r_irq_d;
    logic              r_gie;
    logic              r_pgie;
    logic [DATA_W-1:0] r_epc;
    logic [2:0]        r_int_id;

    logic [N_IRQ-1:0]  w_edge;
    logic [N_IRQ-1:0]  w_en;
    logic [N_IRQ-1:0]  w_w1c;
    logic [N_IRQ-1:0]  w_svc_clr;
    logic [N_IRQ-1:0]  w_pend_nxt;
    logic              w_req;
    logic              w_sel_vld;
    logic [2:0]        w_sel;
    logic              w_mask_we;
    logic              w_pend_we;
    logic              w_epc_we;
    logic              w_drained;

    logic              w_stall;
    logic              w_flush;
    logic              w_redirect;
    logic [DATA_W-1:0] w_target;
    logic              w_active;
    logic [DATA_W-1:0] w_rdata;

    assign w_edge    = bus.irq & ~r_irq_d;
    assign w_en      = r_pend & r_mask;
    assign w_req     = r_gie & (|w_en);
    assign w_drained = ~bus.mem_busy & ~bus.jump_busy & bus.id_valid;

    assign w_mask_we = bus.csr_we & (bus.csr_addr == INT_MASK);
    assign w_pend_we = bus.csr_we & (bus.csr_addr == INT_PEND);
    assign w_epc_we  = bus.csr_we & (bus.csr_addr == INT_EPC);

    // PEND update: W1C and the serviced bit clear, a fresh edge always wins
    assign w_w1c      = w_pend_we ? bus.csr_wdata[N_IRQ-1:0] : '0;
    assign w_svc_clr  = ((r_state == ST_CAPTURE) && w_sel_vld) ? (N_IRQ'(1'b1) << w_sel) : '0;
    assign w_pend_nxt = (r_pend & ~(w_w1c | w_svc_clr)) | w_edge;

    int_prio_enc #(
        .N (N_IRQ)
    ) u_prio_enc (
        .i_req   (w_en),
        .o_valid (w_sel_vld),
        .o_idx   (w_sel)
    );

    // Sequencer state register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state decode; DRAIN re-checks req every cycle so a mask or W1C change aborts
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE:    w_next_state = w_req ? ST_DRAIN : ST_IDLE;
            ST_DRAIN: begin
                if (!w_req) begin
                    w_next_state = ST_IDLE;
                end else if (w_drained) begin
                    w_next_state = ST_CAPTURE;
                end else begin
                    w_next_state = ST_DRAIN;
                end
            end
            ST_CAPTURE: w_next_state = ST_SERVICE;
            ST_SERVICE: w_next_state = bus.iret ? ST_RETURN : ST_SERVICE;
            ST_RETURN:  w_next_state = ST_IDLE;
            default:    w_next_state = ST_IDLE;
        endcase
    end

    // Moore output decode from the registered state
    always_comb begin
        w_stall    = 1'b0;
        w_flush    = 1'b0;
        w_redirect = 1'b0;
        w_target   = '0;
        w_active   = 1'b0;
        case (r_state)
            ST_IDLE:  w_stall = 1'b0;
            ST_DRAIN: w_stall = 1'b1;
            ST_CAPTURE: begin
                w_stall    = 1'b1;
                w_flush    = 1'b1;
                w_redirect = 1'b1;
                // wraps modulo 2^DATA_W by construction
                w_target   = VEC_BASE + (DATA_W'(w_sel) * DATA_W'(VEC_STRIDE));
            end
            ST_SERVICE: w_active = 1'b1;
            ST_RETURN: begin
                w_flush    = 1'b1;
                w_redirect = 1'b1;
                w_target   = r_epc;
                w_active   = 1'b1;
            end
            default: w_stall = 1'b0;
        endcase
    end

    // CSR and edge-detect registers; CAPTURE/RETURN side effects are written last so they take priority
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_mask   <= '0;
            r_gie    <= 1'b0;
            r_pgie   <= 1'b0;
            r_pend   <= '0;
            r_epc    <= '0;
            r_int_id <= 3'd0;
            r_irq_d  <= '0;
        end else begin
            r_irq_d <= bus.irq;
            r_pend  <= w_pend_nxt;
            if (w_mask_we) begin
                r_mask <= bus.csr_wdata[N_IRQ-1:0];
                r_gie  <= bus.csr_wdata[GIE_BIT];
            end
            if (w_epc_we) begin
                r_epc <= bus.csr_wdata;
            end
            if (r_state == ST_CAPTURE) begin
                r_epc    <= bus.pc_id;
                r_pgie   <= r_gie;
                r_gie    <= 1'b0;
                r_int_id <= w_sel;
            end
            if (r_state == ST_RETURN) begin
                r_gie <= r_pgie;
            end
        end
    end

    // CSR read mux, fields zero-extended
    always_comb begin
        w_rdata = '0;
        case (bus.csr_addr)
            INT_MASK: begin
                w_rdata[N_IRQ-1:0] = r_mask;
                w_rdata[GIE_BIT]   = r_gie;
            end
            INT_PEND:  w_rdata[N_IRQ-1:0] = r_pend;
            INT_EPC:   w_rdata = r_epc;
            INT_CAUSE: begin
                w_rdata[GIE_BIT] = w_active;
                w_rdata[2:0]     = r_int_id;
            end
            default: w_rdata = '0;
        endcase
    end

    assign bus.csr_rdata   = w_rdata;
    assign bus.stall       = w_stall;
    assign bus.flush       = w_flush;
    assign bus.pc_redirect = w_redirect;
    assign bus.pc_target   = w_target;
    assign bus.int_active  = w_active;
    assign bus.int_id      = r_int_id;

endmodule

// File: tb/tb_int_ctrl.sv
// -----------------------------------------------------------------------------
// tb_int_ctrl
// Self-checking bench for int_ctrl: directed sequences, a vector table and a
// randomized run compared every cycle against a behavioural model.
// -----------------------------------------------------------------------------
module tb_int_ctrl;

    localparam int N  = 4;
    localparam int DW = 16;

    logic clk = 1'b0;
    logic rst_n;
    logic mon_en;
    int   n_checks;
    int   n_errors;

    int_ctrl_if #(.N_IRQ(N), .DATA_W(DW)) bus ();

    int_ctrl #(
        .N_IRQ      (N),
        .DATA_W     (DW),
        .VEC_BASE   (16'h0040),
        .VEC_STRIDE (4)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // ---------------- behavioural reference model ----------------
    logic [3:0]  m_mask, m_pend, m_irqd, n_mask, n_pend, n_irqd;
    logic        m_gie, m_pgie, n_gie, n_pgie;
    logic [15:0] m_epc, n_epc;
    logic [2:0]  m_id, n_id;
    // phase flags: waiting for drain, vectoring, in handler, returning
    logic        m_wait, m_vec, m_hand, m_ret, n_wait, n_vec, n_hand, n_ret;
    logic [3:0]  m_en, m_low;
    int          m_sel;
    logic        m_req;
    logic        e_stall, e_flush, e_redir, e_active;
    logic [15:0] e_target, e_rdata;

    // next model state from the current one and the bench-driven inputs
    always_comb begin
        m_en   = m_pend & m_mask;
        m_low  = m_en & (~m_en + 4'd1);
        m_sel  = $clog2(m_low);
        m_req  = m_gie && (m_en != 4'd0);
        n_pend = m_pend & ~((bus.csr_we && bus.csr_addr == 2'd1) ? bus.csr_wdata[3:0] : 4'd0);
        if (m_vec) n_pend = n_pend & ~m_low;
        n_pend = n_pend | (bus.irq & ~m_irqd);
        n_irqd = bus.irq;
        n_mask = m_mask; n_gie = m_gie; n_pgie = m_pgie; n_epc = m_epc; n_id = m_id;
        if (bus.csr_we && bus.csr_addr == 2'd0) begin
            n_mask = bus.csr_wdata[3:0];
            n_gie  = bus.csr_wdata[15];
        end
        if (bus.csr_we && bus.csr_addr == 2'd2) n_epc = bus.csr_wdata;
        if (m_vec) begin
            n_pgie = m_gie; n_gie = 1'b0; n_epc = bus.pc_id; n_id = 3'(m_sel);
        end
        if (m_ret) n_gie = m_pgie;
        n_wait = 1'b0; n_vec = 1'b0; n_hand = 1'b0; n_ret = 1'b0;
        if (m_wait) begin
            n_vec  = m_req && !bus.mem_busy && !bus.jump_busy && bus.id_valid;
            n_wait = m_req && !n_vec;
        end else if (m_vec) begin
            n_hand = 1'b1;
        end else if (m_hand) begin
            n_ret  = bus.iret;
            n_hand = !bus.iret;
        end else if (!m_ret) begin
            n_wait = m_req;
        end
        if (!rst_n) begin
            n_mask = 4'd0; n_pend = 4'd0; n_irqd = 4'd0; n_gie = 1'b0; n_pgie = 1'b0;
            n_epc = 16'd0; n_id = 3'd0; n_wait = 1'b0; n_vec = 1'b0; n_hand = 1'b0; n_ret = 1'b0;
        end
    end

    // model registers
    always @(posedge clk) begin
        m_mask <= n_mask; m_pend <= n_pend; m_irqd <= n_irqd; m_gie <= n_gie; m_pgie <= n_pgie;
        m_epc <= n_epc; m_id <= n_id; m_wait <= n_wait; m_vec <= n_vec; m_hand <= n_hand; m_ret <= n_ret;
    end

    // model outputs
    always_comb begin
        e_stall  = m_wait | m_vec;
        e_flush  = m_vec | m_ret;
        e_redir  = m_vec | m_ret;
        e_active = m_hand | m_ret;
        e_target = m_vec ? (16'h0040 + 16'(m_sel * 4)) : (m_ret ? m_epc : 16'h0000);
        case (bus.csr_addr)
            2'd0:    e_rdata = {m_gie, 11'd0, m_mask};
            2'd1:    e_rdata = {12'd0, m_pend};
            2'd2:    e_rdata = m_epc;
            default: e_rdata = {e_active, 12'd0, m_id};
        endcase
    end

    // ---------------- checking helpers ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // mid-cycle comparison of every output against the model
    always @(negedge clk) begin
        if (mon_en) begin
            check("mon_stall",  32'(bus.stall),       32'(e_stall));
            check("mon_flush",  32'(bus.flush),       32'(e_flush));
            check("mon_redir",  32'(bus.pc_redirect), 32'(e_redir));
            check("mon_target", 32'(bus.pc_target),   32'(e_target));
            check("mon_active", 32'(bus.int_active),  32'(e_active));
            check("mon_id",     32'(bus.int_id),      32'(m_id));
            check("mon_rdata",  32'(bus.csr_rdata),   32'(e_rdata));
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic csr_write(input logic [1:0] a, input logic [15:0] d);
        bus.csr_we = 1'b1; bus.csr_addr = a; bus.csr_wdata = d;
        step(1);
        bus.csr_we = 1'b0;
    endtask

    task automatic rd_chk(input string name, input logic [1:0] a, input logic [15:0] exp);
        bus.csr_addr = a;
        #1;
        check(name, 32'(bus.csr_rdata), 32'(exp));
    endtask

    task automatic pulse_iret();
        bus.iret = 1'b1;
        step(1);
        bus.iret = 1'b0;
    endtask

    task automatic wait_redir(input int max_cyc);
        int k;
        k = 0;
        while (!bus.pc_redirect && k < max_cyc) begin
            step(1);
            k++;
        end
        check("redir_seen", 32'(bus.pc_redirect), 32'd1);
    endtask

    task automatic chk_all_zero(input string name);
        check({name, "_stall"},  32'(bus.stall),       32'd0);
        check({name, "_flush"},  32'(bus.flush),       32'd0);
        check({name, "_redir"},  32'(bus.pc_redirect), 32'd0);
        check({name, "_target"}, 32'(bus.pc_target),   32'd0);
        check({name, "_active"}, 32'(bus.int_active),  32'd0);
        check({name, "_id"},     32'(bus.int_id),      32'd0);
    endtask

    typedef struct {
        logic [15:0] mask;
        logic [3:0]  irq;
        logic [15:0] target;
        logic [2:0]  id;
        logic [3:0]  pend_left;
    } vec_t;

    vec_t tbl [5];

    initial begin
        tbl[0] = '{16'h800F, 4'b1111, 16'h0040, 3'd0, 4'b1110};
        tbl[1] = '{16'h8008, 4'b1111, 16'h004C, 3'd3, 4'b0111};
        tbl[2] = '{16'h8006, 4'b0100, 16'h0048, 3'd2, 4'b0000};
        tbl[3] = '{16'h800A, 4'b1010, 16'h0044, 3'd1, 4'b1000};
        tbl[4] = '{16'h8003, 4'b0011, 16'h0040, 3'd0, 4'b0010};

        n_checks = 0; n_errors = 0; mon_en = 1'b0;
        rst_n = 1'b0;
        bus.irq = 4'd0; bus.csr_we = 1'b0; bus.csr_addr = 2'd0; bus.csr_wdata = 16'd0;
        bus.pc_id = 16'h0012; bus.id_valid = 1'b1; bus.mem_busy = 1'b0;
        bus.jump_busy = 1'b0; bus.iret = 1'b0;
        step(2);
        mon_en = 1'b1;

        // reset state
        chk_all_zero("rst");
        for (int a = 0; a < 4; a++) rd_chk("rst_rdata", 2'(a), 16'h0000);
        rst_n = 1'b1;

        // basic entry / exit with exact latency
        csr_write(2'd0, 16'h8001);
        bus.irq = 4'b0001; step(1); bus.irq = 4'b0000;
        rd_chk("a_pend", 2'd1, 16'h0001);
        check("a_idle_stall", 32'(bus.stall), 32'd0);
        step(1);
        check("a_drain_stall", 32'(bus.stall), 32'd1);
        check("a_drain_redir", 32'(bus.pc_redirect), 32'd0);
        step(1);
        check("a_cap_stall", 32'(bus.stall), 32'd1);
        check("a_cap_flush", 32'(bus.flush), 32'd1);
        check("a_cap_redir", 32'(bus.pc_redirect), 32'd1);
        check("a_cap_target", 32'(bus.pc_target), 32'h0040);
        step(1);
        check("a_svc_active", 32'(bus.int_active), 32'd1);
        check("a_svc_id", 32'(bus.int_id), 32'd0);
        check("a_svc_stall", 32'(bus.stall), 32'd0);
        rd_chk("a_epc", 2'd2, 16'h0012);
        rd_chk("a_mask_gie0", 2'd0, 16'h0001);
        rd_chk("a_cause", 2'd3, 16'h8000);
        pulse_iret();
        check("a_ret_redir", 32'(bus.pc_redirect), 32'd1);
        check("a_ret_target", 32'(bus.pc_target), 32'h0012);
        check("a_ret_flush", 32'(bus.flush), 32'd1);
        check("a_ret_active", 32'(bus.int_active), 32'd1);
        step(1);
        check("a_idle_active", 32'(bus.int_active), 32'd0);
        rd_chk("a_mask_gie1", 2'd0, 16'h8001);

        // two simultaneous sources, lowest first, then the remaining one
        csr_write(2'd0, 16'h800C);
        bus.irq = 4'b1100; step(1); bus.irq = 4'b0000;
        wait_redir(8);
        check("b_vec2", 32'(bus.pc_target), 32'h0048);
        step(1);
        check("b_id2", 32'(bus.int_id), 32'd2);
        rd_chk("b_pend", 2'd1, 16'h0008);
        pulse_iret(); step(1);
        wait_redir(8);
        check("b_vec3", 32'(bus.pc_target), 32'h004C);
        step(1);
        check("b_id3", 32'(bus.int_id), 32'd3);
        pulse_iret(); step(1);

        // mem_busy holds DRAIN for three cycles
        csr_write(2'd0, 16'h8001);
        bus.mem_busy = 1'b1;
        bus.irq = 4'b0001; step(1); bus.irq = 4'b0000;
        step(1);
        for (int i = 0; i < 3; i++) begin
            check("c_drain_stall", 32'(bus.stall), 32'd1);
            check("c_drain_noredir", 32'(bus.pc_redirect), 32'd0);
            if (i == 2) bus.mem_busy = 1'b0;
            step(1);
        end
        check("c_cap_redir", 32'(bus.pc_redirect), 32'd1);
        check("c_cap_target", 32'(bus.pc_target), 32'h0040);
        step(1); pulse_iret(); step(1);

        // DRAIN abort through MASK write, then W1C racing an edge
        csr_write(2'd0, 16'h8001);
        bus.jump_busy = 1'b1;
        bus.irq = 4'b0001; step(1); bus.irq = 4'b0000;
        step(1);
        check("d_drain_stall", 32'(bus.stall), 32'd1);
        csr_write(2'd0, 16'h8000);
        step(1);
        check("d_abort_stall", 32'(bus.stall), 32'd0);
        rd_chk("d_pend_kept", 2'd1, 16'h0001);
        bus.jump_busy = 1'b0;
        bus.irq = 4'b0010;
        csr_write(2'd1, 16'h0002);
        bus.irq = 4'b0000;
        rd_chk("d_set_wins", 2'd1, 16'h0003);
        csr_write(2'd1, 16'h000F);
        rd_chk("d_w1c_all", 2'd1, 16'h0000);

        // reset during CAPTURE
        csr_write(2'd0, 16'h8001);
        bus.pc_id = 16'h0034;
        bus.irq = 4'b0001; step(1); bus.irq = 4'b0000;
        step(2);
        check("e_cap_redir", 32'(bus.pc_redirect), 32'd1);
        rst_n = 1'b0;
        step(1);
        chk_all_zero("e_rst");
        rd_chk("e_mask", 2'd0, 16'h0000);
        rd_chk("e_epc", 2'd2, 16'h0000);
        rst_n = 1'b1;
        step(1);

        // vector table
        for (int r = 0; r < 5; r++) begin
            csr_write(2'd1, 16'h000F);
            csr_write(2'd0, tbl[r].mask);
            bus.irq = tbl[r].irq; step(1); bus.irq = 4'b0000;
            wait_redir(8);
            check("tbl_target", 32'(bus.pc_target), 32'(tbl[r].target));
            step(1);
            check("tbl_id", 32'(bus.int_id), 32'(tbl[r].id));
            rd_chk("tbl_pend", 2'd1, {12'd0, tbl[r].pend_left});
            csr_write(2'd0, 16'h0000);
            pulse_iret(); step(1);
        end

        // randomized traffic against the model
        for (int c = 0; c < 3000; c++) begin
            bus.irq       = bus.irq ^ (($urandom_range(0, 5) == 0) ? 4'($urandom) : 4'd0);
            bus.mem_busy  = ($urandom_range(0, 3) == 0);
            bus.jump_busy = ($urandom_range(0, 3) == 0);
            bus.id_valid  = ($urandom_range(0, 7) != 0);
            bus.iret      = ($urandom_range(0, 5) == 0);
            bus.pc_id     = 16'($urandom);
            bus.csr_addr  = 2'($urandom);
            bus.csr_wdata = 16'($urandom);
            bus.csr_we    = ($urandom_range(0, 9) == 0);
            if (bus.csr_addr == 2'd0) bus.csr_wdata[15] = ($urandom_range(0, 3) != 0);
            rst_n         = ($urandom_range(0, 499) != 0);
            step(1);
        end
        rst_n = 1'b1; bus.csr_we = 1'b0; bus.iret = 1'b0;
        step(2);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
